// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and constants for the hex keypad scanner
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } state_t;

   localparam logic [3:0] COL_RESET = 4'b1110;

   // Indexed [row][col]; row 3 carries the E/0/F/D keys of the usual hex pad.
   localparam logic [3:0] KEY_MAP [0:3][0:3] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'hE, 4'h0, 4'hF, 4'hD}
   };

   function automatic logic [1:0] low_index(input logic [3:0] v);
      logic [1:0] idx;
      if (!v[0])      idx = 2'd0;
      else if (!v[1]) idx = 2'd1;
      else if (!v[2]) idx = 2'd2;
      else            idx = 2'd3;
      return idx;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous level inputs
module sync_2ff #(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 hex keypad column scanner with press/release debounce
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV     = 10000,
   parameter int DEBOUNCE_CNT = 100000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [3:0] row_i,
   output logic [3:0] col_o,
   output logic [3:0] key_o,
   output logic       key_valid_o,
   output logic [7:0] data_o,
   output logic       busy_o
);

   localparam int TW = $clog2(SCAN_DIV);
   localparam int DW = $clog2(DEBOUNCE_CNT);
   localparam logic [TW-1:0] TICK_MAX = TW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CNT - 1);

   logic          r_rst_meta;
   logic          r_rst_core;
   logic [3:0]    w_rs;
   state_t        r_state;
   state_t        w_state_nx;
   logic [TW-1:0] r_tick;
   logic [DW-1:0] r_deb;
   logic [3:0]    r_col;
   logic [1:0]    r_col_idx;
   logic [1:0]    r_row;
   logic [3:0]    r_key;
   logic          r_key_valid;
   logic [7:0]    r_data;
   logic          w_tick_tc;
   logic          w_any_low;
   logic          w_row_low;
   logic          w_deb_max;
   logic          w_busy;
   logic          w_latch;
   logic          w_rotate;
   logic          w_accept;
   logic          w_tick_run;
   logic          w_deb_inc;

   // Reset asserts straight through, releases two clocks later on clk_i.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rst_meta <= 1'b1;
         r_rst_core <= 1'b1;
      end else begin
         r_rst_meta <= 1'b0;
         r_rst_core <= r_rst_meta;
      end
   end

   sync_2ff #(
      .WIDTH     (4),
      .RESET_VAL (4'hF)
   ) u_row_sync (
      .i_clk (clk_i),
      .i_rst (r_rst_core),
      .i_d   (row_i),
      .o_q   (w_rs)
   );

   assign w_tick_tc = (r_tick == TICK_MAX);
   assign w_any_low = (w_rs != 4'hF);
   assign w_row_low = ~w_rs[r_row];
   assign w_deb_max = (r_deb == DEB_MAX);

   always_ff @(posedge clk_i or posedge r_rst_core) begin
      if (r_rst_core) r_state <= SCAN;
      else            r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      unique case (r_state)
         SCAN: begin
            if (w_tick_tc && w_any_low) w_state_nx = DEBOUNCE;
         end
         DEBOUNCE: begin
            if (!w_row_low)     w_state_nx = SCAN;
            else if (w_deb_max) w_state_nx = HELD;
         end
         HELD: begin
            if (!w_row_low && w_deb_max) w_state_nx = SCAN;
         end
         default: w_state_nx = SCAN;
      endcase
   end

   // The one debounce counter counts low cycles in DEBOUNCE and high cycles in HELD.
   always_comb begin
      w_busy     = 1'b0;
      w_latch    = 1'b0;
      w_rotate   = 1'b0;
      w_accept   = 1'b0;
      w_tick_run = 1'b0;
      w_deb_inc  = 1'b0;
      unique case (r_state)
         SCAN: begin
            w_tick_run = 1'b1;
            w_latch    = w_tick_tc && w_any_low;
            w_rotate   = w_tick_tc && !w_any_low;
         end
         DEBOUNCE: begin
            w_busy    = 1'b1;
            w_accept  = w_row_low && w_deb_max;
            w_deb_inc = w_row_low && !w_deb_max;
         end
         HELD: begin
            w_busy    = 1'b1;
            w_rotate  = !w_row_low && w_deb_max;
            w_deb_inc = !w_row_low && !w_deb_max;
         end
         default: begin
            w_busy = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge r_rst_core) begin
      if (r_rst_core) begin
         r_tick    <= '0;
         r_deb     <= '0;
         r_col     <= COL_RESET;
         r_col_idx <= 2'd0;
         r_row     <= 2'd0;
      end else begin
         if (w_tick_run && !w_tick_tc) r_tick <= r_tick + 1'b1;
         else                          r_tick <= '0;
         if (w_deb_inc) r_deb <= r_deb + 1'b1;
         else           r_deb <= '0;
         if (w_rotate) r_col <= {r_col[2:0], r_col[3]};
         if (w_latch) begin
            r_col_idx <= low_index(r_col);
            r_row     <= low_index(w_rs);
         end
      end
   end

   always_ff @(posedge clk_i or posedge r_rst_core) begin
      if (r_rst_core) begin
         r_key       <= 4'h0;
         r_key_valid <= 1'b0;
         r_data      <= 8'h00;
      end else begin
         r_key_valid <= w_accept;
         if (w_accept) begin
            r_key  <= KEY_MAP[r_row][r_col_idx];
            r_data <= {r_data[3:0], KEY_MAP[r_row][r_col_idx]};
         end
      end
   end

   assign col_o       = r_col;
   assign key_o       = r_key;
   assign key_valid_o = r_key_valid;
   assign data_o      = r_data;
   assign busy_o      = w_busy;

endmodule
